// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - load/store responder over a word-wide synchronous RAM
// Byte/halfword stores are a read-modify-write; loads are formatted per funct3.
module mem_responder #(
    parameter int WORDS = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_err
);
    localparam int AW = $clog2(WORDS);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_we;
    logic [2:0]      r_funct3;
    logic [1:0]      r_off;
    logic [15:0]     r_wdata;
    logic [AW-1:0]   r_idx;
    logic            r_err;
    logic [31:0]     r_rdata;
    logic [31:0]     r_ram_q;
    logic [31:0]     r_mem [WORDS];

    logic [AW-1:0]   w_idx_in;
    logic            w_bad;
    logic            w_accept;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_idx;
    logic [31:0]     w_mem_wdata;
    logic [31:0]     w_merged;
    logic [31:0]     w_load;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic            w_unused;

    // Upper address bits are deliberately ignored so addresses wrap modulo WORDS.
    assign w_unused = ^i_addr[31:AW+2];
    assign w_idx_in = i_addr[AW+1:2];
    assign w_accept = (r_state == S_IDLE) && i_req;

    always_comb begin
        w_bad = 1'b0;
        case (i_funct3)
            3'b000:         w_bad = 1'b0;
            3'b001:         w_bad = i_addr[0];
            3'b010:         w_bad = |i_addr[1:0];
            3'b100, 3'b101: w_bad = i_we | (i_funct3[0] & i_addr[0]);
            default:        w_bad = 1'b1;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_req) begin
                    w_next = (w_bad || (i_we && i_funct3 == 3'b010)) ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_merged = r_ram_q;
        if (r_funct3[0]) begin
            if (r_off[1]) w_merged[31:16] = r_wdata;
            else          w_merged[15:0]  = r_wdata;
        end else begin
            case (r_off)
                2'd0:    w_merged[7:0]   = r_wdata[7:0];
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end
    end

    assign w_byte = r_ram_q[{r_off, 3'b000} +: 8];
    assign w_half = r_off[1] ? r_ram_q[31:16] : r_ram_q[15:0];

    always_comb begin
        w_load = r_ram_q;
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = r_ram_q;
        endcase
    end

    // Aligned SW writes straight from the inputs; SB/SH write the merged word in ACCESS.
    assign w_mem_we    = (w_accept && !w_bad && i_we && i_funct3 == 3'b010)
                       || (r_state == S_ACCESS && r_we);
    assign w_mem_idx   = (r_state == S_ACCESS) ? r_idx : w_idx_in;
    assign w_mem_wdata = (r_state == S_ACCESS) ? w_merged : i_wdata;

    always_ff @(posedge i_clk) begin
        if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wdata;
        if (w_accept) r_ram_q <= r_mem[w_idx_in];
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_off    <= 2'd0;
            r_wdata  <= 16'd0;
            r_idx    <= '0;
            r_err    <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we     <= i_we;
                r_funct3 <= i_funct3;
                r_off    <= i_addr[1:0];
                r_wdata  <= i_wdata[15:0];
                r_idx    <= w_idx_in;
                r_err    <= w_bad;
            end else if (r_state == S_RESP) begin
                r_err <= 1'b0;
            end
            if (r_state == S_ACCESS && !r_we) r_rdata <= w_load;
        end
    end

    assign o_rdata = r_rdata;
    assign o_ready = (r_state == S_RESP);
    assign o_err   = r_err;
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder
// Driver pushes expected {err, rdata}; a negedge monitor pops on every ready.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_req = 1'b0;
    logic        i_we = 1'b0;
    logic [2:0]  i_funct3 = 3'd0;
    logic [31:0] i_addr = 32'd0;
    logic [31:0] i_wdata = 32'd0;
    logic [31:0] o_rdata;
    logic        o_ready;
    logic        o_err;

    int n_vec = 0;
    int n_bad = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;

    mem_responder #(.WORDS(1024)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_req(i_req), .i_we(i_we),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_rdata(o_rdata), .o_ready(o_ready), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (i_reset && o_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_rdata", o_rdata, mon_e[31:0]);
                chk("resp_err", {31'd0, o_err}, {31'd0, mon_e[32]});
            end
        end
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_err, input int exp_lat, input bit pulse);
        int lat;
        exp_q.push_back({exp_err, exp_rd});
        @(negedge clk);
        i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = a; i_wdata = wd;
        @(posedge clk);
        #1 i_req = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (pulse && lat == 1) i_req = 1'b1;
        end while (o_ready !== 1'b1 && lat < 20);
        i_req = 1'b0;
        chk("latency", lat, exp_lat);
        @(posedge clk);
        #1;
        chk("ready_one_cycle", {31'd0, o_ready}, 32'd0);
        chk("err_cleared", {31'd0, o_err}, 32'd0);
    endtask

    task automatic quiet(input int n);
        int cnt;
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (o_ready === 1'b1) cnt++;
        end
        chk("no_extra_ready", cnt, 0);
    endtask

    initial begin
        #2 i_reset = 1'b0;
        #1;
        chk("reset_rdata", o_rdata, 32'd0);
        chk("reset_ready", {31'd0, o_ready}, 32'd0);
        chk("reset_err", {31'd0, o_err}, 32'd0);
        repeat (2) @(negedge clk);
        i_reset = 1'b1;

        // word path
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1, 1'b0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0);
        // byte path
        do_req(1'b1, 3'b000, 32'h11, 32'h000000AA, 32'hDEADBEEF, 1'b0, 2, 1'b0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0, 2, 1'b0);
        do_req(1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 1'b0);
        do_req(1'b0, 3'b100, 32'h11, 32'h0, 32'h000000AA, 1'b0, 2, 1'b0);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 1'b0);
        // halfword path
        do_req(1'b1, 3'b001, 32'h12, 32'h00001234, 32'hFFFFFFDE, 1'b0, 2, 1'b0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h1234AAEF, 1'b0, 2, 1'b0);
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 32'h00001234, 1'b0, 2, 1'b0);
        do_req(1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFAAEF, 1'b0, 2, 1'b0);
        do_req(1'b0, 3'b101, 32'h10, 32'h0, 32'h0000AAEF, 1'b0, 2, 1'b0);
        // errors: rdata holds the last load
        do_req(1'b0, 3'b010, 32'h13, 32'h0, 32'h0000AAEF, 1'b1, 1, 1'b0);
        do_req(1'b1, 3'b001, 32'h11, 32'hFFFFFFFF, 32'h0000AAEF, 1'b1, 1, 1'b0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h1234AAEF, 1'b0, 2, 1'b0);
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 32'h1234AAEF, 1'b1, 1, 1'b0);
        do_req(1'b1, 3'b100, 32'h10, 32'h0, 32'h1234AAEF, 1'b1, 1, 1'b0);

        // reset between E0 and E1 of SB 0x10
        @(negedge clk);
        i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b000; i_addr = 32'h10; i_wdata = 32'h55;
        @(posedge clk);
        #1 i_req = 1'b0;
        #1 i_reset = 1'b0;
        #1;
        chk("abort_ready", {31'd0, o_ready}, 32'd0);
        chk("abort_rdata", o_rdata, 32'd0);
        #1 i_reset = 1'b1;
        quiet(3);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h1234AAEF, 1'b0, 2, 1'b0);

        // req pulsed during ACCESS is ignored
        do_req(1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, 2, 1'b1);
        quiet(4);

        // aliasing modulo WORDS
        do_req(1'b0, 3'b010, 32'h10 + 32'd4096, 32'h0, 32'h1234AAEF, 1'b0, 2, 1'b0);
        do_req(1'b1, 3'b010, 32'h14 + 32'd4096, 32'hCAFEF00D, 32'h1234AAEF, 1'b0, 1, 1'b0);
        do_req(1'b0, 3'b010, 32'h14, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1'b0);

        // async reset while RESP of an error response
        exp_q.push_back({1'b1, 32'hCAFEF00D});
        @(negedge clk);
        i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h13;
        @(posedge clk);
        #1 i_req = 1'b0;
        @(negedge clk);
        chk("resp_before_reset", {31'd0, o_ready}, 32'd1);
        #2 i_reset = 1'b0;
        #1;
        chk("async_ready", {31'd0, o_ready}, 32'd0);
        chk("async_err", {31'd0, o_err}, 32'd0);
        chk("async_rdata", o_rdata, 32'd0);
        #1 i_reset = 1'b1;
        quiet(3);

        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
